cbus_arbiter: RTL and testbench

- Shares the single MMU cbus port between NUM_REQ requesters: index 0 is instruction fetch, index 1 is data access, and further indices are optional.
- Sits between the core-side bus masters and the mmu. Grants one whole cbus transaction at a time and routes the response back to the granted requester only.
- Round-robin arbitration, so a stream of loads cannot starve fetch, and the reverse.

---
 rtl/cbus_arbiter_pkg.sv | 22 ++
 rtl/cbus_arbiter_rr_pick.sv | 30 +++
 rtl/cbus_arbiter.sv | 76 +++++++
 tb/tb_cbus_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_arbiter_pkg.sv
// rtl/cbus_arbiter_pkg.sv - cbus request/response types shared by cbus masters and the mmu
package cbus_arbiter_pkg;

  localparam int NUM_CBUS_REQ = 2;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strobe;
    logic [2:0]  size;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// rtl/cbus_arbiter_rr_pick.sv - combinational round-robin picker, scans upward from last_idx+1
module cbus_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  int               idx;
  logic [IDX_W-1:0] idx_w;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx   = (int'(last_idx) + k) % NUM_REQ;
      idx_w = IDX_W'(idx);
      if (!any_valid && valid[idx_w]) begin
        winner    = idx_w;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - grants the single mmu cbus port to one requester per whole transaction
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_CBUS_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  cbus_req_t  [NUM_REQ-1:0]   ireq,
  output cbus_resp_t [NUM_REQ-1:0]   iresp,
  output cbus_req_t                  oreq,
  input  cbus_resp_t                 oresp,
  output logic                       grant_valid,
  output logic [IDX_W-1:0]           grant_idx
);

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t BUSY  = 2'd1;
  localparam arb_state_t DRAIN = 2'd2;

  arb_state_t         state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last_idx;
  logic [NUM_REQ-1:0] req_valid;
  logic [IDX_W-1:0]   winner;
  logic               any_valid;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) req_valid[i] = ireq[i].valid;
  end

  cbus_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid     (req_valid),
    .last_idx  (last_idx),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      last_idx <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          owner    <= winner;
          last_idx <= winner;
          state    <= BUSY;
        end
        BUSY: if (oresp.ready && oresp.last) state <= DRAIN;
        default: state <= IDLE;
      endcase
    end
  end

  // Pure pass-through while owned, so owner-side mid-transaction updates (including dropping valid) reach the mmu.
  always_comb begin
    oreq  = '0;
    iresp = '0;
    if (state == BUSY) begin
      oreq         = ireq[owner];
      iresp[owner] = oresp;
    end
  end

  assign grant_valid = (state == BUSY);
  assign grant_idx   = owner;

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb/tb_cbus_arbiter.sv - directed bench for cbus_arbiter with a small latency/burst mmu model
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int IW = 1;

  logic             clk = 1'b0;
  logic             reset;
  cbus_req_t        ireq_arr [N];
  cbus_req_t  [N-1:0] ireq;
  cbus_resp_t [N-1:0] iresp;
  cbus_req_t        oreq;
  cbus_resp_t       oresp;
  logic             grant_valid;
  logic [IW-1:0]    grant_idx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_comb for (int i = 0; i < N; i++) ireq[i] = ireq_arr[i];

  cbus_arbiter #(.NUM_REQ(N), .IDX_W(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .ireq        (ireq),
    .iresp       (iresp),
    .oreq        (oreq),
    .oresp       (oresp),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // mmu model: after mmu_lat cycles returns mmu_beats consecutive beats, data = mmu_rdata + beat
  int          mmu_lat   = 5;
  int          mmu_beats = 1;
  logic [63:0] mmu_rdata = 64'h13;
  int          cnt, beat;
  logic        mbusy, mdone;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 0; beat <= 0; mbusy <= 1'b0; mdone <= 1'b0; oresp <= '0;
    end else begin
      oresp <= '0;
      if (!oreq.valid) mdone <= 1'b0;
      if (!mbusy && !mdone && oreq.valid) begin
        mbusy <= 1'b1; cnt <= 1; beat <= 0;
      end else if (mbusy) begin
        if (cnt >= mmu_lat) begin
          oresp.ready <= 1'b1;
          oresp.last  <= (beat == mmu_beats - 1);
          oresp.data  <= mmu_rdata + 64'(beat);
          beat        <= beat + 1;
          if (beat == mmu_beats - 1) begin
            mbusy <= 1'b0; mdone <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  int          resp_cnt [N] = '{default: 0};
  int          beat_cnt [N] = '{default: 0};
  logic [63:0] last_data [N];
  int          leak_cnt = 0;
  int          addr_glitch = 0;
  int          grants [$];
  logic        prev_gv = 1'b0, prev_ov = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (iresp[i].ready) begin
        beat_cnt[i]++;
        if (iresp[i].last) begin
          resp_cnt[i]++;
          last_data[i] = iresp[i].data;
        end
        if (!(grant_valid && grant_idx == i)) leak_cnt++;
      end
    end
    if (grant_valid && !prev_gv) grants.push_back(int'(grant_idx));
    if (oreq.valid && prev_ov && oreq.addr != prev_addr) addr_glitch++;
    prev_gv   = grant_valid;
    prev_ov   = oreq.valid;
    prev_addr = oreq.addr;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic cbus_req_t mk_req(input logic wr, input logic [31:0] addr,
                                       input logic [63:0] data, input logic [7:0] strb,
                                       input logic [2:0] size, input logic [7:0] len);
    cbus_req_t r;
    r.valid = 1'b1; r.is_write = wr; r.addr = addr; r.data = data;
    r.strobe = strb; r.size = size; r.len = len;
    return r;
  endfunction

  task automatic run_req(input int idx, input cbus_req_t r, input string tag);
    int t;
    t = 0;
    ireq_arr[idx] = r;
    while (!(iresp[idx].ready && iresp[idx].last) && t < 300) begin
      tick();
      t++;
    end
    chk({tag, "_tmo"}, 64'(t < 300), 64'd1);
    ireq_arr[idx].valid = 1'b0;
    tick();
  endtask

  initial begin
    int t, g0, r0, r1, b0, nl;
    cbus_req_t wr;
    reset = 1'b0;
    for (int i = 0; i < N; i++) ireq_arr[i] = '0;
    #1;
    chk("rst_gv", 64'(grant_valid), 64'd0);
    chk("rst_gidx", 64'(grant_idx), 64'd0);
    chk("rst_oreq", 64'(oreq == '0), 64'd1);
    chk("rst_iresp", 64'(iresp == '0), 64'd1);
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Contention: fresh after reset, index 0 wins first, address only changes across DRAIN
    g0 = grants.size();
    fork
      run_req(0, mk_req(1'b0, 32'h8000_0000, '0, '0, 3'd3, '0), "cont0");
      run_req(1, mk_req(1'b0, 32'h8000_1000, '0, '0, 3'd3, '0), "cont1");
    join
    repeat (2) tick();
    chk("cont_ngrants", 64'(grants.size() - g0), 64'd2);
    chk("cont_first", 64'(grants[g0]), 64'd0);
    chk("cont_second", 64'(grants[g0 + 1]), 64'd1);
    chk("cont_addr_glitch", 64'(addr_glitch), 64'd0);

    // Fairness: last owner was 1, so the sequence restarts at 0 and alternates
    g0 = grants.size();
    fork
      for (int k = 0; k < 8; k++) run_req(0, mk_req(1'b0, 32'h8000_0000, '0, '0, 3'd3, '0), "fair0");
      for (int k = 0; k < 8; k++) run_req(1, mk_req(1'b0, 32'h8000_1000, '0, '0, 3'd3, '0), "fair1");
    join
    repeat (2) tick();
    chk("fair_ngrants", 64'(grants.size() - g0), 64'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("fair_g%0d", i), 64'(grants[g0 + i]), 64'(i % 2));

    // Single fetch
    r0 = resp_cnt[0]; r1 = resp_cnt[1]; b0 = beat_cnt[1];
    mmu_lat = 5; mmu_beats = 1; mmu_rdata = 64'h13;
    ireq_arr[0] = mk_req(1'b0, 32'h8000_0000, '0, '0, 3'd3, '0);
    #1;
    chk("fetch_idle_nofwd", 64'(oreq.valid), 64'd0);
    tick();
    chk("fetch_lat", 64'(oreq.valid), 64'd1);
    chk("fetch_addr", 64'(oreq.addr), 64'h8000_0000);
    chk("fetch_gidx", 64'(grant_idx), 64'd0);
    t = 0;
    while (!(iresp[0].ready && iresp[0].last) && t < 100) begin tick(); t++; end
    chk("fetch_tmo", 64'(t < 100), 64'd1);
    chk("fetch_data", iresp[0].data, 64'h13);
    ireq_arr[0].valid = 1'b0;
    tick();
    chk("fetch_drain_ov", 64'(oreq.valid), 64'd0);
    chk("fetch_drain_gv", 64'(grant_valid), 64'd0);
    tick();
    chk("fetch_idle_gv", 64'(grant_valid), 64'd0);
    chk("fetch_idle_gidx", 64'(grant_idx), 64'd0);
    chk("fetch_once", 64'(resp_cnt[0] - r0), 64'd1);
    chk("fetch_no_resp1", 64'(resp_cnt[1] - r1), 64'd0);
    chk("fetch_no_beat1", 64'(beat_cnt[1] - b0), 64'd0);

    // Write forwarding on requester 1
    b0 = beat_cnt[0]; r1 = resp_cnt[1];
    mmu_lat = 3;
    wr = mk_req(1'b1, 32'h8000_2000, 64'hDEAD_BEEF, 8'hFF, 3'd3, 8'd0);
    ireq_arr[1] = wr;
    tick();
    chk("wr_owner", 64'(grant_idx), 64'd1);
    chk("wr_is_write", 64'(oreq.is_write), 64'd1);
    chk("wr_strobe", 64'(oreq.strobe), 64'hFF);
    chk("wr_data", oreq.data, 64'hDEAD_BEEF);
    chk("wr_size", 64'(oreq.size), 64'd3);
    chk("wr_len", 64'(oreq.len), 64'd0);
    run_req(1, wr, "wr");
    chk("wr_ack", 64'(resp_cnt[1] - r1), 64'd1);
    chk("wr_no_ready0", 64'(beat_cnt[0] - b0), 64'd0);

    // Burst of 4 beats; BUSY must hold across the first three
    b0 = beat_cnt[0];
    mmu_beats = 4; mmu_rdata = 64'h100;
    ireq_arr[0] = mk_req(1'b0, 32'h8000_3000, '0, '0, 3'd3, 8'd3);
    t = 0; nl = 0;
    while (!(iresp[0].ready && iresp[0].last) && t < 100) begin
      if (iresp[0].ready && grant_valid) nl++;
      tick(); t++;
    end
    chk("burst_tmo", 64'(t < 100), 64'd1);
    chk("burst_busy_beats", 64'(nl), 64'd3);
    chk("burst_last_data", iresp[0].data, 64'h103);
    ireq_arr[0].valid = 1'b0;
    tick();
    chk("burst_beats", 64'(beat_cnt[0] - b0), 64'd4);
    chk("burst_left_busy", 64'(grant_valid), 64'd0);
    tick();

    // Async reset mid-BUSY from owner 0, then the first grant must go to 0 again
    mmu_beats = 1; mmu_lat = 10;
    r0 = resp_cnt[0];
    ireq_arr[0] = mk_req(1'b0, 32'h8000_4000, '0, '0, 3'd3, '0);
    tick(); tick();
    chk("ar_busy", 64'(grant_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_oreq_valid", 64'(oreq.valid), 64'd0);
    chk("ar_gv", 64'(grant_valid), 64'd0);
    chk("ar_iresp", 64'(iresp == '0), 64'd1);
    ireq_arr[0] = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("ar_no_resp", 64'(resp_cnt[0] - r0), 64'd0);
    mmu_lat = 2;
    g0 = grants.size();
    fork
      run_req(0, mk_req(1'b0, 32'h8000_0000, '0, '0, 3'd3, '0), "ar0");
      run_req(1, mk_req(1'b0, 32'h8000_1000, '0, '0, 3'd3, '0), "ar1");
    join
    chk("ar_first_grant", 64'(grants[g0]), 64'd0);
    chk("leak", 64'(leak_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
